grad_integrator: RTL

Inverse of the image-gradient stage. It streams packed {Gx,Gy} words out of the gradient memory in raster order and reconstructs the 8-bit image by running integration. Each reconstructed pixel is written to the image memory at one pixel per cycle. It sits on the same gradient/image memory pair as the gradient generator, with the roles reversed: it is the reader of the gradient memory and the writer of the image memory. Its main use is round-trip self-check and decompression.

---
 rtl/ig_pkg.sv | 20 ++
 rtl/pix_accum.sv | 28 ++
 rtl/grad_integrator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ig_pkg.sv
// Shared word format and state encoding for the gradient/image memory pair.
// The gradient generator and the integrator both import this package.
package ig_pkg;

    localparam int GRAD_W  = 20;
    localparam int GX_MSB  = 19;
    localparam int GX_LSB  = 10;
    localparam int GY_MSB  = 9;
    localparam int GY_LSB  = 0;
    localparam int PIX_W   = 8;
    localparam int DELTA_W = GX_MSB - GX_LSB + 1;
    localparam int SUM_W   = DELTA_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ig_state_e;

endpackage

// File: rtl/pix_accum.sv
// Adds a signed 10-bit gradient to an unsigned 8-bit pixel and saturates to 0..255.
// The clamp flag reports that saturation happened.
module pix_accum
    import ig_pkg::*;
(
    input  logic [PIX_W-1:0]   base,
    input  logic [DELTA_W-1:0] delta,
    output logic [PIX_W-1:0]   result,
    output logic               clamped
);

    logic signed [SUM_W-1:0] sum;

    assign sum = $signed({{(SUM_W-PIX_W){1'b0}}, base}) + $signed({delta[DELTA_W-1], delta});

    always_comb begin
        result  = sum[PIX_W-1:0];
        clamped = 1'b0;
        if (sum < 0) begin
            result  = '0;
            clamped = 1'b1;
        end else if (sum > $signed(SUM_W'(255))) begin
            result  = '1;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/grad_integrator.sv
// Streams {Gx,Gy} words in raster order and rebuilds the 8-bit image by running
// integration, writing one reconstructed pixel per cycle to the image memory.
module grad_integrator
    import ig_pkg::*;
#(
    parameter int W_LOG2 = 8,
    parameter int H_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PIX_W-1:0]         seed,
    output logic                     grad_rd,
    output logic [W_LOG2+H_LOG2-1:0] grad_addr,
    input  logic [GRAD_W-1:0]        grad_di,
    output logic                     img_wr,
    output logic [W_LOG2+H_LOG2-1:0] img_addr,
    output logic [PIX_W-1:0]         img_do,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW    = W_LOG2 + H_LOG2;
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] N_PIX   = CNT_W'(1) << AW;
    localparam logic [CNT_W-1:0] LAST_WR = N_PIX - CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_RD = N_PIX - CNT_W'(2);

    ig_state_e state_q, state_d;

    logic [CNT_W-1:0]  rd_cnt, wr_cnt;
    logic [PIX_W-1:0]  seed_q, pix, col0_next;
    logic [PIX_W-1:0]  gx_pix, gy_pix, next_pix;
    logic              gx_clamp, gy_clamp, next_clamp;
    logic [W_LOG2-1:0] col;
    logic              row_last, wr_last;

    assign col      = wr_cnt[W_LOG2-1:0];
    assign row_last = (wr_cnt[AW-1:W_LOG2] == '1);
    assign wr_last  = (wr_cnt == LAST_WR);

    pix_accum u_gx_path (
        .base    (pix),
        .delta   (grad_di[GX_MSB:GX_LSB]),
        .result  (gx_pix),
        .clamped (gx_clamp)
    );

    pix_accum u_gy_path (
        .base    (pix),
        .delta   (grad_di[GY_MSB:GY_LSB]),
        .result  (gy_pix),
        .clamped (gy_clamp)
    );

    // Row starts take the column-0 value stored one row earlier; otherwise integrate Gx.
    always_comb begin
        next_pix   = gx_pix;
        next_clamp = gx_clamp;
        if (wr_cnt == '0) begin
            next_pix   = seed_q;
            next_clamp = 1'b0;
        end else if (col == '0) begin
            next_pix   = col0_next;
            next_clamp = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (wr_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grad_rd   <= 1'b0;
            grad_addr <= '0;
            img_wr    <= 1'b0;
            img_addr  <= '0;
            img_do    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            seed_q    <= '0;
            pix       <= '0;
            col0_next <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    grad_rd <= 1'b0;
                    img_wr  <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        seed_q    <= seed;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        grad_rd   <= 1'b1;
                        grad_addr <= '0;
                        rd_cnt    <= CNT_W'(1);
                        wr_cnt    <= '0;
                    end
                end
                RUN: begin
                    // Word N-1 is never needed, so reads end at address N-2.
                    if (rd_cnt <= LAST_RD) begin
                        grad_rd   <= 1'b1;
                        grad_addr <= rd_cnt[AW-1:0];
                        rd_cnt    <= rd_cnt + CNT_W'(1);
                    end else begin
                        grad_rd <= 1'b0;
                    end
                    img_wr   <= 1'b1;
                    img_addr <= wr_cnt[AW-1:0];
                    img_do   <= next_pix;
                    pix      <= next_pix;
                    wr_cnt   <= wr_cnt + CNT_W'(1);
                    if (next_clamp) err <= 1'b1;
                    // Word for column 0 is on grad_di while column 1 is built; pix is P(r,0).
                    if (col == W_LOG2'(1)) begin
                        col0_next <= gy_pix;
                        if (gy_clamp && !row_last) err <= 1'b1;
                    end
                end
                DONE: begin
                    grad_rd <= 1'b0;
                    img_wr  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    grad_rd <= 1'b0;
                    img_wr  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
